// File: rtl/pipelined_memory.sv
// Single-port word memory with valid/ready request and response channels,
// byte-lane writes, fixed read latency, credit-limited response FIFO and zeroing after reset.
//
// state  | meaning
// S_IDLE | one-cycle hold after reset when no clear is wanted
// S_INIT | zeroing one word per cycle, requests blocked
// S_RUN  | memory usable, requests accepted against credits
module pipelined_memory #(
  parameter int WIDTH       = 16,
  parameter int DEPTH       = 64,
  parameter int ADDR_WIDTH  = $clog2(DEPTH),
  parameter int RD_LAT      = 2,
  parameter int INIT_ON_RST = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0]      req_wdata,
  input  logic [WIDTH/8-1:0]    req_be,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_rdata,
  output logic                  rsp_err,
  output logic                  init_done
);

  localparam int NB     = WIDTH / 8;
  localparam int FD     = RD_LAT + 1;
  localparam int FIW    = (FD > 1) ? $clog2(FD) : 1;
  localparam int FPW    = $clog2(FD + 1);
  localparam int PIPE_N = (RD_LAT > 1) ? RD_LAT - 1 : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN} state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_init_addr;
  logic                  w_init_last;

  logic [WIDTH-1:0]      r_mem [DEPTH];

  logic                  w_acc, w_pop, w_err;
  logic [WIDTH-1:0]      w_acc_data;
  logic [FPW-1:0]        r_out;

  logic                  r_pv [PIPE_N];
  logic                  r_pe [PIPE_N];
  logic [WIDTH-1:0]      r_pd [PIPE_N];
  logic                  w_push_v, w_push_e;
  logic [WIDTH-1:0]      w_push_d;

  logic [WIDTH-1:0]      r_fd [FD];
  logic                  r_fe [FD];
  logic [FIW-1:0]        r_wp, r_rp;
  logic [FPW-1:0]        r_cnt;

  function automatic logic [FIW-1:0] ptr_inc(input logic [FIW-1:0] p);
    return (p == FIW'(FD - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_init_last = (r_init_addr == ADDR_WIDTH'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= (INIT_ON_RST != 0) ? S_INIT : S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = S_RUN;
      S_INIT:  if (w_init_last) w_state_nxt = S_RUN;
      S_RUN:   w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                    r_init_addr <= '0;
    else if (r_state == S_INIT) r_init_addr <= r_init_addr + 1'b1;
  end

  assign init_done  = (r_state == S_RUN);
  assign req_ready  = (r_state == S_RUN) && (r_out < FPW'(FD));
  assign w_acc      = req_valid && req_ready && !rst;
  assign w_pop      = rsp_valid && rsp_ready;
  assign w_err      = ({1'b0, req_addr} >= DEPTH_W);
  assign w_acc_data = (req_wr || w_err) ? '0 : r_mem[req_addr];

  // Out-of-range writes are dropped here rather than wrapped onto a real word.
  always_ff @(posedge clk) begin
    if (!rst && r_state == S_INIT) begin
      r_mem[r_init_addr] <= '0;
    end else if (w_acc && req_wr && !w_err) begin
      for (int b = 0; b < NB; b++)
        if (req_be[b]) r_mem[req_addr][8*b +: 8] <= req_wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out <= '0;
    end else begin
      case ({w_acc, w_pop})
        2'b10:   r_out <= r_out + 1'b1;
        2'b01:   r_out <= r_out - 1'b1;
        default: r_out <= r_out;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE_N; i++) r_pv[i] <= 1'b0;
    end else begin
      r_pv[0] <= w_acc;
      r_pe[0] <= w_err;
      r_pd[0] <= w_acc_data;
      for (int i = 1; i < PIPE_N; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pe[i] <= r_pe[i-1];
        r_pd[i] <= r_pd[i-1];
      end
    end
  end

  // With single-cycle latency the accepted result goes straight into the FIFO.
  assign w_push_v = (RD_LAT == 1) ? w_acc      : r_pv[PIPE_N-1];
  assign w_push_e = (RD_LAT == 1) ? w_err      : r_pe[PIPE_N-1];
  assign w_push_d = (RD_LAT == 1) ? w_acc_data : r_pd[PIPE_N-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push_v) begin
        r_fd[r_wp] <= w_push_d;
        r_fe[r_wp] <= w_push_e;
        r_wp       <= ptr_inc(r_wp);
      end
      if (w_pop) r_rp <= ptr_inc(r_rp);
      case ({w_push_v, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign rsp_valid = (r_cnt != '0);
  assign rsp_rdata = rsp_valid ? r_fd[r_rp] : '0;
  assign rsp_err   = rsp_valid && r_fe[r_rp];

endmodule

// File: tb/tb_pipelined_memory.sv
// Bench for pipelined_memory: directed scenarios plus random traffic, all checked
// against a queue-based model of accepted requests and their due cycles.
module tb_pipelined_memory;
  localparam int WIDTH  = 16;
  localparam int DEPTH  = 48;
  localparam int AW     = 6;
  localparam int RD_LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1;
  logic             req_valid = 1'b0, req_wr = 1'b0, rsp_ready = 1'b0;
  logic [AW-1:0]    req_addr = '0;
  logic [WIDTH-1:0] req_wdata = '0;
  logic [1:0]       req_be = '0;
  logic             req_ready, rsp_valid, rsp_err, init_done;
  logic [WIDTH-1:0] rsp_rdata;

  pipelined_memory #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RD_LAT(RD_LAT), .INIT_ON_RST(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .init_done(init_done));

  typedef struct { logic [WIDTH-1:0] d; logic e; int t; } rsp_t;

  rsp_t             q[$];
  logic [16:0]      got_q[$];
  logic [WIDTH-1:0] m_mem [64];
  int               cyc = 0, run_at = 0;
  bit               m_known = 0, acc_last = 0;
  int               n_checks = 0, n_err = 0;
  logic             obs_ready, obs_valid, obs_err, obs_done;
  logic [WIDTH-1:0] obs_rdata;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  function automatic bit exp_run();   return m_known && (cyc >= run_at); endfunction
  function automatic bit exp_ready(); return exp_run() && (q.size() < RD_LAT + 1); endfunction
  function automatic bit exp_valid(); return (q.size() > 0) && (cyc >= q[0].t); endfunction
  function automatic logic [16:0] got(input int i);
    return (i < got_q.size()) ? got_q[i] : 17'bx;
  endfunction

  task automatic compare();
    obs_ready = req_ready; obs_valid = rsp_valid; obs_err = rsp_err;
    obs_rdata = rsp_rdata; obs_done  = init_done;
    if (!m_known) return;
    chk("req_ready", {31'b0, obs_ready}, {31'b0, exp_ready()});
    chk("init_done", {31'b0, obs_done},  {31'b0, exp_run()});
    chk("rsp_valid", {31'b0, obs_valid}, {31'b0, exp_valid()});
    if (exp_valid()) begin
      chk("rsp_rdata", {16'b0, obs_rdata}, {16'b0, q[0].d});
      chk("rsp_err",   {31'b0, obs_err},   {31'b0, q[0].e});
    end
  endtask

  // One clock: check outputs, drive inputs, advance the model for the coming edge.
  task automatic cycle(input logic rs, input logic v, input logic wr, input logic [AW-1:0] a,
                       input logic [WIDTH-1:0] d, input logic [1:0] be, input logic rr);
    bit rdy, vld;
    rsp_t r;
    @(negedge clk);
    compare();
    rst = rs; req_valid = v; req_wr = wr; req_addr = a; req_wdata = d; req_be = be; rsp_ready = rr;
    acc_last = 0;
    rdy = exp_ready();
    vld = exp_valid();
    if (rs) begin
      q.delete(); got_q.delete();
      run_at  = cyc + 1 + DEPTH;
      m_known = 1;
      foreach (m_mem[i]) m_mem[i] = '0;
    end else if (m_known) begin
      if (obs_valid && rr) got_q.push_back({obs_err, obs_rdata});
      if (vld && rr) void'(q.pop_front());
      if (v && rdy) begin
        acc_last = 1;
        r.t = cyc + RD_LAT;
        r.e = (a >= DEPTH);
        r.d = (wr || r.e) ? '0 : m_mem[a];
        if (wr && !r.e)
          for (int b = 0; b < 2; b++) if (be[b]) m_mem[a][8*b +: 8] = d[8*b +: 8];
        q.push_back(r);
      end
    end
  endtask

  task automatic idle(input logic rr);
    cycle(1'b0, 1'b0, 1'b0, '0, '0, '0, rr);
  endtask

  task automatic do_reset();
    int cnt = 0;
    cycle(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    for (int k = 0; k < 200; k++) begin
      idle(1'b1);
      if (k == 0) begin
        chk("rst_rsp_valid", {31'b0, obs_valid}, 0);
        chk("rst_rsp_rdata", {16'b0, obs_rdata}, 0);
        chk("rst_rsp_err",   {31'b0, obs_err},   0);
        chk("rst_req_ready", {31'b0, obs_ready}, 0);
      end
      if (obs_done) break;
      cnt++;
    end
    chk("init_len", cnt, DEPTH);
  endtask

  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [WIDTH-1:0] d,
                       input logic [1:0] be, input logic rr);
    for (int k = 0; k < 50; k++) begin
      cycle(1'b0, 1'b1, wr, a, d, be, rr);
      if (acc_last) break;
    end
    if (!acc_last) chk("issue_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int k = 0; k < 100; k++) begin
      if (q.size() == 0) break;
      idle(1'b1);
    end
    chk("drain", q.size(), 0);
  endtask

  initial begin
    int nrdy;
    do_reset();

    // Freshly cleared word
    issue(1'b0, 6'd5, '0, '0, 1'b1); drain();
    chk("t1_rd5", got(0), {1'b0, 16'h0000});

    // Byte lanes
    got_q.delete();
    issue(1'b1, 6'd3, 16'hABCD, 2'b11, 1'b1);
    issue(1'b1, 6'd3, 16'h1200, 2'b10, 1'b1);
    issue(1'b0, 6'd3, '0, '0, 1'b1);
    drain();
    chk("t2_wr1", got(0), {1'b0, 16'h0000});
    chk("t2_wr2", got(1), {1'b0, 16'h0000});
    chk("t2_rd",  got(2), {1'b0, 16'h12CD});

    // Out of range
    got_q.delete();
    issue(1'b1, 6'd50, 16'hFFFF, 2'b11, 1'b1);
    issue(1'b0, 6'd50, '0, '0, 1'b1);
    issue(1'b0, 6'd2, '0, '0, 1'b1);
    drain();
    chk("t5_wr50", got(0), {1'b1, 16'h0000});
    chk("t5_rd50", got(1), {1'b1, 16'h0000});
    chk("t5_rd2",  got(2), {1'b0, 16'h0000});

    // Back-to-back reads
    for (int i = 0; i < 8; i++) issue(1'b1, AW'(i), 16'h10 + 16'(i), 2'b11, 1'b1);
    drain();
    got_q.delete();
    nrdy = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, 1'b0, AW'(i), '0, '0, 1'b1);
      nrdy += int'(obs_ready);
    end
    drain();
    chk("t3_ready", nrdy, 8);
    for (int i = 0; i < 8; i++) chk("t3_data", got(i), {1'b0, 16'h10 + 16'(i)});

    // Backpressure
    got_q.delete();
    nrdy = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b1, 1'b0, AW'(i), '0, '0, 1'b0);
      nrdy += int'(obs_ready);
    end
    idle(1'b0);
    chk("t4_accepts", nrdy, 3);
    chk("t4_hold_valid", {31'b0, obs_valid}, 1);
    chk("t4_hold_data",  {16'b0, obs_rdata}, 32'h10);
    drain();
    idle(1'b1);
    chk("t4_ready_back", {31'b0, obs_ready}, 1);
    for (int i = 0; i < 3; i++) chk("t4_data", got(i), {1'b0, 16'h10 + 16'(i)});

    // Reset with responses pending
    issue(1'b0, 6'd4, '0, '0, 1'b0);
    issue(1'b0, 6'd5, '0, '0, 1'b0);
    do_reset();
    for (int i = 0; i < 6; i++) idle(1'b1);
    chk("t6_no_stale", got_q.size(), 0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(0, 599) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
            AW'($urandom_range(0, 63)), 16'($urandom), 2'($urandom),
            ($urandom_range(0, 3) != 0));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
